// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and helpers for the serial audio transmitter
//
// Purpose: frame-mode enum, channel limit and frame-length helper used by codec_i2s_tx.
// Ports: none (package).
package audio_pkg;

  typedef enum logic {
    MODE_I2S = 1'b0,
    MODE_TDM = 1'b1
  } frame_mode_e;

  localparam int MAX_CHANNELS = 8;

  function automatic int frame_bits(input int channels, input int slot_w);
    return channels * slot_w;
  endfunction

  function automatic frame_mode_e frame_mode(input int channels);
    return (channels > 2) ? MODE_TDM : MODE_I2S;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - bit-clock divider with single-cycle fall/rise enables
//
// Purpose: divides clk by 2*BCLK_DIV to produce the codec bit clock and flags
//          the clk cycle on whose edge the bit clock toggles.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   i_en        enable; low holds the divider and bit clock at 0
//   o_bclk      registered bit clock
//   o_fall      high in the cycle whose clk edge drives o_bclk 1->0
//   o_rise      high in the cycle whose clk edge drives o_bclk 0->1
module i2s_clkgen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_bclk,
  output logic o_fall,
  output logic o_rise
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DW-1:0] r_div;
  logic          r_bclk;
  logic          w_wrap;

  assign w_wrap = i_en && (r_div == DW'(BCLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (!i_en) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (w_wrap) begin
      r_div  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

  assign o_bclk = r_bclk;
  assign o_fall = w_wrap && r_bclk;
  assign o_rise = w_wrap && !r_bclk;

endmodule

// File: rtl/codec_i2s_tx.sv
// rtl/codec_i2s_tx.sv - parametrised I2S/TDM serial audio transmitter
//
// Purpose: one-frame holding buffer with valid/ready, frame shifter and bit
//          counter driving a codec in I2S (2 channels) or TDM (>2 channels)
//          format. Repeats the last frame when no new frame is ready.
//          Optional crossfeed on buffer loads when AUDIO_MIX_EN is defined.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   en           transmitter enable
//   mix          crossfeed enable (only with AUDIO_MIX_EN)
//   in_data      CHANNELS samples, ch0 in the low SAMPLE_W bits
//   in_valid     in_data valid
//   in_ready     holding buffer empty
//   frame_tick   one-clk pulse per frame load
//   underrun     one-clk pulse when the last frame was repeated
//   aud_bclk     codec bit clock
//   aud_lrck     codec word/frame clock
//   aud_dat      codec serial data
module codec_i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int CHANNELS = 2,
  parameter int BCLK_DIV = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         mix,
  input  logic [CHANNELS*SAMPLE_W-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         frame_tick,
  output logic                         underrun,
  output logic                         aud_bclk,
  output logic                         aud_lrck,
  output logic                         aud_dat
);

  localparam int          FRAME_W = frame_bits(CHANNELS, SLOT_W);
  localparam int          BW      = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int          DATA_W  = CHANNELS * SAMPLE_W;
  localparam frame_mode_e MODE    = frame_mode(CHANNELS);

  logic              w_fall;
  logic              w_rise_unused;
  logic [DATA_W-1:0] w_mixed;
  logic              w_wrap;
  logic [BW-1:0]     w_bit_next;
  logic              w_lrck_next;

  logic [DATA_W-1:0]  r_buf;
  logic               r_full;
  logic               r_in_ready;
  logic [DATA_W-1:0]  r_last;
  logic [FRAME_W-1:0] r_shift;
  logic [BW-1:0]      r_bit;
  logic               r_start;
  logic               r_lrck;
  logic               r_dat;
  logic               r_frame_tick;
  logic               r_underrun;

  // Data launches on the bit-clock fall; the rise enable has no consumer here.
  i2s_clkgen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clkgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (en),
    .o_bclk (aud_bclk),
    .o_fall (w_fall),
    .o_rise (w_rise_unused)
  );

  // Lays the samples out as the wire stream: stream bit 0 sits at the MSB so
  // the shifter simply shifts left. Slot bits past the sample stay zero.
  function automatic logic [FRAME_W-1:0] to_stream(input logic [DATA_W-1:0] d);
    logic [FRAME_W-1:0] s;
    s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < SAMPLE_W; k++) begin
        s[FRAME_W-1-(c*SLOT_W+k)] = d[c*SAMPLE_W+SAMPLE_W-1-k];
      end
    end
    return s;
  endfunction

`ifdef AUDIO_MIX_EN
  logic signed [SAMPLE_W+1:0] w_l, w_r, w_lm, w_rm;

  // SAMPLE_W+2 signed bits hold 3*x+y for any pair without overflow.
  always_comb begin
    w_mixed = r_buf;
    w_l     = '0;
    w_r     = '0;
    w_lm    = '0;
    w_rm    = '0;
    if (mix) begin
      for (int j = 0; j < CHANNELS/2; j++) begin
        w_l  = (SAMPLE_W+2)'($signed(r_buf[(2*j)*SAMPLE_W +: SAMPLE_W]));
        w_r  = (SAMPLE_W+2)'($signed(r_buf[(2*j+1)*SAMPLE_W +: SAMPLE_W]));
        w_lm = (w_l + w_l + w_l + w_r) >>> 2;
        w_rm = (w_r + w_r + w_r + w_l) >>> 2;
        w_mixed[(2*j)*SAMPLE_W +: SAMPLE_W]   = w_lm[SAMPLE_W-1:0];
        w_mixed[(2*j+1)*SAMPLE_W +: SAMPLE_W] = w_rm[SAMPLE_W-1:0];
      end
    end
  end
`else
  logic w_mix_unused;
  assign w_mix_unused = mix;
  assign w_mixed      = r_buf;
`endif

  // After reset or a disable, the first fall always starts a fresh frame.
  assign w_wrap     = r_start || (r_bit == BW'(FRAME_W - 1));
  assign w_bit_next = w_wrap ? '0 : r_bit + 1'b1;
  assign w_lrck_next = (MODE == MODE_I2S) ? (w_bit_next >= BW'(SLOT_W))
                                          : (w_bit_next == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf        <= '0;
      r_full       <= 1'b0;
      r_in_ready   <= 1'b1;
      r_last       <= '0;
      r_shift      <= '0;
      r_bit        <= '0;
      r_start      <= 1'b1;
      r_lrck       <= 1'b0;
      r_dat        <= 1'b0;
      r_frame_tick <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      r_underrun   <= 1'b0;

      // in_ready is low whenever the buffer is full, so a write never
      // collides with the load that empties it.
      if (in_valid && r_in_ready) begin
        r_buf      <= in_data;
        r_full     <= 1'b1;
        r_in_ready <= 1'b0;
      end

      if (!en) begin
        r_bit   <= '0;
        r_start <= 1'b1;
        r_lrck  <= 1'b0;
        r_dat   <= 1'b0;
      end else if (w_fall) begin
        r_bit  <= w_bit_next;
        r_lrck <= w_lrck_next;
        if (w_wrap) begin
          r_start      <= 1'b0;
          r_frame_tick <= 1'b1;
          // One-bit delay: the old frame's last bit goes out with the load.
          r_dat        <= r_start ? 1'b0 : r_shift[FRAME_W-1];
          r_shift      <= to_stream(r_full ? w_mixed : r_last);
          if (r_full) begin
            r_last     <= r_buf;
            r_full     <= 1'b0;
            r_in_ready <= 1'b1;
          end else begin
            r_underrun <= 1'b1;
          end
        end else begin
          r_dat   <= r_shift[FRAME_W-1];
          r_shift <= r_shift << 1;
        end
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign frame_tick = r_frame_tick;
  assign underrun   = r_underrun;
  assign aud_lrck   = r_lrck;
  assign aud_dat    = r_dat;

endmodule

// File: doc/codec_i2s_tx.md
Name: codec_i2s_tx

Overview:
Parametrised serial audio transmitter that replaces the fixed 2-channel codec shifter in the board audio path. It generates BCLK and LRCK from the system clock and serialises CHANNELS signed samples per frame, MSB first. Frame format is I2S for 2 channels and TDM for more. A one-frame holding buffer with a valid/ready handshake decouples the core's sample producer; the block repeats the last frame on underrun.

Parameters:
SAMPLE_W, 16, sample width in bits (1..SLOT_W)
SLOT_W, 32, bits per channel slot on the wire; bits below the sample are zero-padded
CHANNELS, 2, channel count: even, 2..8; 2 selects I2S, more than 2 selects TDM
BCLK_DIV, 4, clk cycles per BCLK half-period (at least 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  transmitter enable
mix  in  1  crossfeed enable (used only with AUDIO_MIX_EN)
in_data  in  CHANNELS*SAMPLE_W  frame of samples; ch0 in [SAMPLE_W-1:0]
in_valid  in  1  in_data valid
in_ready  out  1  holding buffer empty
frame_tick  out  1  one-clk pulse when a frame is loaded into the shifter
underrun  out  1  one-clk pulse when a frame was repeated
aud_bclk  out  1  codec bit clock
aud_lrck  out  1  codec frame/word clock
aud_dat  out  1  codec serial data

Behaviour:
- Reset: aud_bclk=0, aud_lrck=0, aud_dat=0, in_ready=1, frame_tick=0, underrun=0, holding buffer empty, last-frame register=0, all counters=0.
- Divider: counts 0..BCLK_DIV-1, toggles aud_bclk on wrap. "Fall" event = toggle 1->0; "rise" = 0->1. The BCLK period is 2*BCLK_DIV clk.
- All of aud_dat, aud_lrck and the bit counter update only on fall events. The codec samples on rise.
- Bit counter b runs 0..CHANNELS*SLOT_W-1 and wraps to 0. Slot s = b/SLOT_W; bit-in-slot k = b%SLOT_W.
- aud_dat carries a one-bit delay: on the fall that enters bit b, it drives bit b-1 of the frame stream. The MSB of slot 0 is on the wire one BCLK after the frame boundary.
- I2S (CHANNELS==2): aud_lrck=0 for b in [0,SLOT_W-1], 1 for b in [SLOT_W,2*SLOT_W-1].
- TDM (CHANNELS>2): aud_lrck=1 only while b==0, otherwise 0.
- Slot bits: k<SAMPLE_W drives sample[SAMPLE_W-1-k], otherwise 0.
- Frame load happens on the fall where b wraps to 0, with frame_tick=1 for that clk:
  - If the buffer is full, the shifter takes the buffer, last-frame := buffer, and the buffer is emptied.
  - If the buffer is empty, the shifter takes last-frame and underrun=1 for that clk.
- Handshake: the buffer is written when in_valid && in_ready; in_ready falls the next clk.
- in_ready is registered. It rises the clk after a load empties the buffer. A write cannot coincide with a load of a full buffer.
- en=0: the divider and bit counter are held at 0 and aud_bclk/aud_lrck/aud_dat are forced to 0 on the next clk. The buffer and handshake stay live. When en returns to 1, the block restarts at b=0 with a frame load on the first fall.
- Asynchronous reset mid-frame: all state returns to reset values immediately. No partial frame resumes.

Optional Feature:
- Macro: AUDIO_MIX_EN.
- With it defined and mix=1, the buffer-to-shifter load applies a crossfeed to each pair (2j, 2j+1):
  - L' = (3*L + R) >>> 2 and R' = (3*R + L) >>> 2.
  - Arithmetic is signed at SAMPLE_W+2 bits, shifted with floor, then truncated to SAMPLE_W. No overflow is possible.
  - last-frame stores the unmixed samples.
- Without the macro, the mix port is present but ignored, and no mix logic is synthesised.

Decomposition:
- Package audio_pkg: I2S/TDM mode enum, MAX_CHANNELS=8, and a function returning frame length in bits (CHANNELS*SLOT_W).
- Sub-module i2s_clkgen: divider, aud_bclk register, and fall/rise single-clk enables with en gating.
- The top level holds the buffer, bit counter, shifter and mix logic.

Test Plan:
- Defaults, BCLK_DIV=2, one frame {ch1=16'h0001, ch0=16'h8000}:
  - Required: after the first loaded frame, the 64-bit wire stream is 1 followed by 31 zeros, then 15 zeros, a 1 and 16 zeros.
  - Required: aud_lrck toggles every 32 BCLK; the frame is 256 clk long.
- Handshake: in_valid held high with an incrementing pattern. Required: exactly one accept per frame_tick, in_ready low for the rest of each frame, and no underrun.
- Underrun: supply one frame 16'h1234/16'h5678, then stop. Required: underrun pulses on each subsequent frame_tick and the same data is repeated on the wire.
- TDM, CHANNELS=4, SLOT_W=16, SAMPLE_W=12, samples 12'hABC on all channels:
  - Required: aud_lrck high for exactly 1 BCLK per 64.
  - Required: each slot carries 101010111100 followed by 4 zeros.
- en dropped at b=20 for 10 clk, then restored. Required: outputs are 0 during the gap, and the restart begins with frame_tick and b=0.
- AUDIO_MIX_EN with mix=1, L=16'sd4000 and R=-16'sd4000. Required: the wire carries L'=2000 and R'=-2000; with mix=0 the wire carries 4000/-4000.
